// File: rtl/a51_keystream_sequencer.sv
// a51_keystream_sequencer
// Drives an external A5/1 LFSR core (R1/R2/R3 with majority clocking) through
// one burst: clear, key load, frame load, mixing, then keystream generation.
// Key bytes arrive from the PS/2 decoder; keystream bytes leave on a
// valid/ready handshake towards the LCD / seven-segment path.
//
// Ports
//   inclock        system clock, rising edge
//   resetn         asynchronous active-low reset
//   key_wr         strobe: shift key_byte into the key register (IDLE only)
//   key_byte[7:0]  key byte; the first byte written ends up in key bits [7:0]
//   frame_num      frame number, latched when start is accepted
//   start          strobe: begin a burst (IDLE only)
//   abort          return to IDLE on the next edge from any state
//   core_clear     synchronous clear of R1/R2/R3
//   core_step      advance the core one step this cycle
//   core_force_all with core_step: clock all registers, XOR core_in_bit into LSBs
//   core_in_bit    key/frame load bit
//   core_ks_bit    XOR of the core register MSBs (combinational in the core)
//   ks_byte[7:0]   keystream byte, first generated bit in bit 7
//   ks_valid       ks_byte valid, held until ks_ready
//   ks_ready       consumer accepts the byte at an edge with ks_valid high
//   busy           high whenever the sequencer is not idle
//   done           one-cycle pulse after the last byte of a burst is accepted
module a51_keystream_sequencer #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int KS_BITS    = 228
) (
    input  logic                  inclock,
    input  logic                  resetn,
    input  logic                  key_wr,
    input  logic [7:0]            key_byte,
    input  logic [FRAME_BITS-1:0] frame_num,
    input  logic                  start,
    input  logic                  abort,
    output logic                  core_clear,
    output logic                  core_step,
    output logic                  core_force_all,
    output logic                  core_in_bit,
    input  logic                  core_ks_bit,
    output logic [7:0]            ks_byte,
    output logic                  ks_valid,
    input  logic                  ks_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int PHASE_MAX = (KEY_BITS > FRAME_BITS)
                             ? ((KEY_BITS > MIX_CYCLES) ? KEY_BITS : MIX_CYCLES)
                             : ((FRAME_BITS > MIX_CYCLES) ? FRAME_BITS : MIX_CYCLES);
    localparam int CNT_W  = $clog2(PHASE_MAX);
    localparam int KS_W   = $clog2(KS_BITS);
    localparam int LOAD_W = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;

    typedef enum logic [3:0] {
        IDLE, CLEAR, KEY, FRAME, MIX, GEN_STEP, GEN_CAP, OUT, DONE
    } state_t;

    state_t                 state_reg;
    logic [KEY_BITS-1:0]    key_reg;
    logic [FRAME_BITS-1:0]  frame_reg;
    // Working copy of the key/frame being fed to the core, so key_reg itself
    // survives an abort in the middle of the load.
    logic [LOAD_W-1:0]      load_sr_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [KS_W-1:0]        ks_cnt_reg;
    logic [2:0]             bit_idx_reg;
    logic [6:0]             ks_sh_reg;
    logic                   last_reg;

    logic core_clear_reg, core_step_reg, core_force_reg, core_in_reg;
    logic [7:0] ks_byte_reg;
    logic ks_valid_reg, busy_reg, done_reg;

    assign core_clear     = core_clear_reg;
    assign core_step      = core_step_reg;
    assign core_force_all = core_force_reg;
    assign core_in_bit    = core_in_reg;
    assign ks_byte        = ks_byte_reg;
    assign ks_valid       = ks_valid_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;

    always_ff @(posedge inclock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            key_reg        <= '0;
            frame_reg      <= '0;
            load_sr_reg    <= '0;
            cnt_reg        <= '0;
            ks_cnt_reg     <= '0;
            bit_idx_reg    <= '0;
            ks_sh_reg      <= '0;
            last_reg       <= 1'b0;
            core_clear_reg <= 1'b0;
            core_step_reg  <= 1'b0;
            core_force_reg <= 1'b0;
            core_in_reg    <= 1'b0;
            ks_byte_reg    <= '0;
            ks_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            // Key bytes are only taken while idle; a byte arriving with start
            // is shifted in first, and CLEAR gives it a cycle to settle.
            if (state_reg == IDLE && key_wr)
                key_reg <= {key_byte, key_reg[KEY_BITS-1:8]};

            if (abort) begin
                state_reg      <= IDLE;
                core_clear_reg <= 1'b0;
                core_step_reg  <= 1'b0;
                core_force_reg <= 1'b0;
                core_in_reg    <= 1'b0;
                ks_valid_reg   <= 1'b0;
                busy_reg       <= 1'b0;
                done_reg       <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            frame_reg      <= frame_num;
                            cnt_reg        <= '0;
                            ks_cnt_reg     <= '0;
                            bit_idx_reg    <= '0;
                            last_reg       <= 1'b0;
                            core_clear_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                            state_reg      <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        core_clear_reg <= 1'b0;
                        core_step_reg  <= 1'b1;
                        core_force_reg <= 1'b1;
                        core_in_reg    <= key_reg[0];
                        load_sr_reg    <= LOAD_W'(key_reg >> 1);
                        cnt_reg        <= '0;
                        state_reg      <= KEY;
                    end
                    KEY: begin
                        if (cnt_reg == CNT_W'(KEY_BITS - 1)) begin
                            core_in_reg <= frame_reg[0];
                            load_sr_reg <= LOAD_W'(frame_reg >> 1);
                            cnt_reg     <= '0;
                            state_reg   <= FRAME;
                        end else begin
                            core_in_reg <= load_sr_reg[0];
                            load_sr_reg <= load_sr_reg >> 1;
                            cnt_reg     <= cnt_reg + CNT_W'(1);
                        end
                    end
                    FRAME: begin
                        if (cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
                            core_force_reg <= 1'b0;
                            core_in_reg    <= 1'b0;
                            cnt_reg        <= '0;
                            state_reg      <= MIX;
                        end else begin
                            core_in_reg <= load_sr_reg[0];
                            load_sr_reg <= load_sr_reg >> 1;
                            cnt_reg     <= cnt_reg + CNT_W'(1);
                        end
                    end
                    MIX: begin
                        // core_step stays high into the first GEN_STEP
                        if (cnt_reg == CNT_W'(MIX_CYCLES - 1)) begin
                            cnt_reg   <= '0;
                            state_reg <= GEN_STEP;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    GEN_STEP: begin
                        core_step_reg <= 1'b0;
                        state_reg     <= GEN_CAP;
                    end
                    GEN_CAP: begin
                        ks_sh_reg   <= {ks_sh_reg[5:0], core_ks_bit};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (ks_cnt_reg != KS_W'(KS_BITS - 1))
                            ks_cnt_reg <= ks_cnt_reg + KS_W'(1);
                        if (bit_idx_reg == 3'd7 || ks_cnt_reg == KS_W'(KS_BITS - 1)) begin
                            // Left-align: a short final byte keeps its bits in
                            // the top positions; stale shifter bits fall off.
                            ks_byte_reg  <= {ks_sh_reg, core_ks_bit} << (3'd7 - bit_idx_reg);
                            ks_valid_reg <= 1'b1;
                            last_reg     <= (ks_cnt_reg == KS_W'(KS_BITS - 1));
                            state_reg    <= OUT;
                        end else begin
                            core_step_reg <= 1'b1;
                            state_reg     <= GEN_STEP;
                        end
                    end
                    OUT: begin
                        // Core stays frozen here, so stalls never lose bits.
                        if (ks_ready) begin
                            ks_valid_reg <= 1'b0;
                            if (last_reg) begin
                                done_reg  <= 1'b1;
                                state_reg <= DONE;
                            end else begin
                                core_step_reg <= 1'b1;
                                state_reg     <= GEN_STEP;
                            end
                        end
                    end
                    DONE: begin
                        done_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_a51_keystream_sequencer.sv
// Bench for a51_keystream_sequencer: an A5/1 stub core answers the core_*
// controls, a reference model computes each burst's expected bytes into a
// queue, and a negedge monitor pops and compares on every handshake.
module tb_a51_keystream_sequencer;

    localparam int KEY_BITS   = 64;
    localparam int FRAME_BITS = 22;
    localparam int MIX_CYCLES = 100;
    localparam int KS_BITS    = 228;
    localparam int NB         = (KS_BITS + 7) / 8;
    localparam int NLOAD      = KEY_BITS + FRAME_BITS;

    logic inclock = 1'b0;
    logic resetn, key_wr, start, abort, ks_ready, core_ks_bit;
    logic [7:0] key_byte;
    logic [FRAME_BITS-1:0] frame_num;
    logic core_clear, core_step, core_force_all, core_in_bit;
    logic [7:0] ks_byte;
    logic ks_valid, busy, done;

    a51_keystream_sequencer #(
        .KEY_BITS(KEY_BITS), .FRAME_BITS(FRAME_BITS),
        .MIX_CYCLES(MIX_CYCLES), .KS_BITS(KS_BITS)
    ) dut (
        .inclock(inclock), .resetn(resetn), .key_wr(key_wr), .key_byte(key_byte),
        .frame_num(frame_num), .start(start), .abort(abort),
        .core_clear(core_clear), .core_step(core_step), .core_force_all(core_force_all),
        .core_in_bit(core_in_bit), .core_ks_bit(core_ks_bit),
        .ks_byte(ks_byte), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .busy(busy), .done(done)
    );

    always #5 inclock = ~inclock;

    // ---------------- A5/1 stub core ----------------
    logic [18:0] c_r1 = '0;
    logic [21:0] c_r2 = '0;
    logic [22:0] c_r3 = '0;
    logic        c_maj;
    assign core_ks_bit = c_r1[18] ^ c_r2[21] ^ c_r3[22];

    always @(posedge inclock) begin
        if (core_clear) begin
            c_r1 <= '0; c_r2 <= '0; c_r3 <= '0;
        end else if (core_step) begin
            if (core_force_all) begin
                c_r1 <= {c_r1[17:0], (^(c_r1 & 19'h72000)) ^ core_in_bit};
                c_r2 <= {c_r2[20:0], (^(c_r2 & 22'h300000)) ^ core_in_bit};
                c_r3 <= {c_r3[21:0], (^(c_r3 & 23'h700080)) ^ core_in_bit};
            end else begin
                c_maj = (c_r1[8] & c_r2[10]) | (c_r1[8] & c_r3[10]) | (c_r2[10] & c_r3[10]);
                if (c_r1[8]  == c_maj) c_r1 <= {c_r1[17:0], ^(c_r1 & 19'h72000)};
                if (c_r2[10] == c_maj) c_r2 <= {c_r2[20:0], ^(c_r2 & 22'h300000)};
                if (c_r3[10] == c_maj) c_r3 <= {c_r3[21:0], ^(c_r3 & 23'h700080)};
            end
        end
    end

    // ---------------- reference model ----------------
    // Classic A5/1 burst: load key then frame bits with all registers clocked,
    // MIX_CYCLES majority steps, then KS_BITS majority steps each yielding
    // one output bit, packed MSB-first and the tail left-aligned.
    function automatic void a51_ref(input logic [63:0] key, input logic [21:0] frame,
                                    output logic [7:0] ks [NB]);
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
        logic [85:0] bits;
        logic [NB*8-1:0] s;
        logic m, b;
        r1 = '0; r2 = '0; r3 = '0; s = '0;
        bits = {frame, key};
        for (int i = 0; i < NLOAD; i++) begin
            b = bits[0];
            bits = bits >> 1;
            r1 = {r1[17:0], (^(r1 & 19'h72000)) ^ b};
            r2 = {r2[20:0], (^(r2 & 22'h300000)) ^ b};
            r3 = {r3[21:0], (^(r3 & 23'h700080)) ^ b};
        end
        for (int i = 0; i < MIX_CYCLES + KS_BITS; i++) begin
            m = (r1[8] + r2[10] + r3[10]) >= 2'd2;
            if (r1[8]  == m) r1 = {r1[17:0], ^(r1 & 19'h72000)};
            if (r2[10] == m) r2 = {r2[20:0], ^(r2 & 22'h300000)};
            if (r3[10] == m) r3 = {r3[21:0], ^(r3 & 23'h700080)};
            if (i >= MIX_CYCLES) s = {s[NB*8-2:0], r1[18] ^ r2[21] ^ r3[22]};
        end
        s = s << (NB * 8 - KS_BITS);
        for (int j = 0; j < NB; j++) begin
            ks[j] = s[NB*8-1 -: 8];
            s = s << 8;
        end
    endfunction

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [63:0] key_model = '0;
    logic [21:0] frame_model = '0;
    int ready_mode = 0;
    int stall_ctl  = 0;

    int busy_cyc, first_valid, clears, clr_step, forced, plain, order_bad, done_cnt, stall_total;
    logic [85:0] inbits;
    logic stall_active = 1'b0;
    logic [7:0] held_byte;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge inclock);
        #1;
    endtask

    // ---------------- ready driver ----------------
    always @(posedge inclock) begin
        #1;
        case (ready_mode)
            0: ks_ready = 1'b1;
            1: begin
                if (ks_valid && got_q.size() == 3 && stall_ctl < 50) begin
                    ks_ready = 1'b0;
                    stall_ctl++;
                end else begin
                    ks_ready = 1'b1;
                end
            end
            default: ks_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // ---------------- monitor ----------------
    always @(negedge inclock) begin
        logic [7:0] e;
        if (resetn) begin
            if (busy) busy_cyc++;
            if (ks_valid && first_valid < 0) first_valid = busy_cyc - 1;
            if (core_clear) clears++;
            if (core_clear && core_step) clr_step++;
            if (core_step && core_force_all) begin
                if (plain > 0) order_bad++;
                inbits = {core_in_bit, inbits[85:1]};
                forced++;
            end
            if (core_step && !core_force_all) plain++;
            if (done) done_cnt++;
            if (ks_valid) begin
                n_checks++;
                if (core_step !== 1'b0) begin
                    n_fail++;
                    $display("FAIL step_while_valid: core_step=%b required 0", core_step);
                end
            end
            if (ks_valid && !ks_ready) begin
                stall_total++;
                if (stall_active) begin
                    n_checks++;
                    if (ks_byte !== held_byte) begin
                        n_fail++;
                        $display("FAIL stall_hold: ks_byte=%02h required %02h", ks_byte, held_byte);
                    end
                end else begin
                    stall_active = 1'b1;
                    held_byte = ks_byte;
                end
            end else begin
                stall_active = 1'b0;
            end
            if (ks_valid && ks_ready && !abort) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_byte: got %02h required none", ks_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (ks_byte !== e) begin
                        n_fail++;
                        $display("FAIL ks_byte[%0d]: got %02h required %02h", got_q.size(), ks_byte, e);
                    end
                    $display("byte %0d: ks_byte=%02h expected=%02h", got_q.size(), ks_byte, e);
                    got_q.push_back(ks_byte);
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic write_key(input logic [7:0] b);
        key_wr = 1'b1;
        key_byte = b;
        key_model = {b, key_model[63:8]};
        tick;
        key_wr = 1'b0;
    endtask

    task automatic start_burst(input logic [21:0] frame, input logic with_wr, input logic [7:0] kb);
        logic [7:0] ks [NB];
        if (with_wr) key_model = {kb, key_model[63:8]};
        frame_model = frame;
        a51_ref(key_model, frame, ks);
        exp_q.delete();
        got_q.delete();
        for (int j = 0; j < NB; j++) exp_q.push_back(ks[j]);
        busy_cyc = 0; first_valid = -1; clears = 0; clr_step = 0; forced = 0; plain = 0;
        order_bad = 0; done_cnt = 0; stall_total = 0; inbits = '0; stall_ctl = 0;
        frame_num = frame;
        start = 1'b1;
        key_wr = with_wr;
        key_byte = kb;
        tick;
        start = 1'b0;
        key_wr = 1'b0;
    endtask

    task automatic finish_burst(input string name, input int mode);
        int n = 0;
        while (done_cnt == 0 && n < 6000) begin
            tick;
            n++;
        end
        check({name, ".done_seen"}, 128'(done_cnt != 0), 128'(1));
        repeat (3) tick;
        check({name, ".done_once"}, 128'(done_cnt), 128'(1));
        check({name, ".bytes"}, 128'(got_q.size()), 128'(NB));
        check({name, ".exp_left"}, 128'(exp_q.size()), 128'(0));
        check({name, ".clears"}, 128'(clears), 128'(1));
        check({name, ".forced"}, 128'(forced), 128'(NLOAD));
        check({name, ".plain"}, 128'(plain), 128'(MIX_CYCLES + KS_BITS));
        check({name, ".clr_step"}, 128'(clr_step), 128'(0));
        check({name, ".order"}, 128'(order_bad), 128'(0));
        check({name, ".load_bits"}, 128'(inbits), 128'({frame_model, key_model}));
        if (mode == 0)
            check({name, ".first_valid"}, 128'(first_valid), 128'(1 + NLOAD + MIX_CYCLES + 16));
        if (mode == 1)
            check({name, ".stall_cycles"}, 128'(stall_total), 128'(50));
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] gkey [8]   = '{8'h12, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] golden [14] = '{8'h53, 8'h4E, 8'hAA, 8'h58, 8'h2F, 8'hE8, 8'h15,
                                8'h1A, 8'hB6, 8'hE1, 8'h85, 8'h5A, 8'h72, 8'h8C};
    logic [7:0] run1 [NB];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0; key_wr = 1'b0; key_byte = '0; frame_num = '0;
        start = 1'b0; abort = 1'b0; ks_ready = 1'b1;
        repeat (3) tick;
        check("reset_outputs",
              128'({core_clear, core_step, core_force_all, core_in_bit, ks_byte, ks_valid, busy, done}),
              128'(0));
        resetn = 1'b1;
        tick;
        check("idle_busy", 128'(busy), 128'(0));

        // Golden key/frame, ready held high, stray start/key_wr during MIX
        for (int i = 0; i < 8; i++) write_key(gkey[i]);
        ready_mode = 0;
        start_burst(22'h134, 1'b0, 8'h00);
        repeat (120) tick;
        start = 1'b1; key_wr = 1'b1; key_byte = 8'hFF; frame_num = 22'h3FFFFF;
        tick;
        start = 1'b0; key_wr = 1'b0;
        finish_burst("golden", 0);
        for (int j = 0; j < 14; j++)
            if (j < got_q.size()) check($sformatf("golden_vec[%0d]", j), 128'(got_q[j]), 128'(golden[j]));
        for (int j = 0; j < NB; j++) run1[j] = (j < got_q.size()) ? got_q[j] : 8'h00;

        // Backpressure on byte 3 for 50 cycles, stray start/key_wr while stalled
        ready_mode = 1;
        start_burst(22'h134, 1'b0, 8'h00);
        n = 0;
        while (stall_total < 10 && n < 2000) begin tick; n++; end
        check("bp_stall_reached", 128'(stall_total >= 10), 128'(1));
        start = 1'b1; key_wr = 1'b1; key_byte = 8'h5C; frame_num = 22'h0F0F0;
        tick;
        start = 1'b0; key_wr = 1'b0;
        finish_burst("backpressure", 1);
        for (int j = 0; j < NB; j++)
            if (j < got_q.size()) check($sformatf("bp_vs_run1[%0d]", j), 128'(got_q[j]), 128'(run1[j]));

        // Abort during generation, then a clean rerun
        ready_mode = 0;
        start_burst(22'h134, 1'b0, 8'h00);
        n = 0;
        while (!(got_q.size() >= 5 && busy && !ks_valid) && n < 2000) begin tick; n++; end
        check("abort_point_reached", 128'(got_q.size() >= 5), 128'(1));
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_idle", 128'({busy, ks_valid, core_step, core_clear, core_force_all}), 128'(0));
        repeat (40) tick;
        check("abort_no_done", 128'(done_cnt), 128'(0));
        check("abort_stays_idle", 128'(busy), 128'(0));
        start_burst(22'h134, 1'b0, 8'h00);
        finish_burst("after_abort", 0);
        for (int j = 0; j < 14; j++)
            if (j < got_q.size()) check($sformatf("rerun_vec[%0d]", j), 128'(got_q[j]), 128'(golden[j]));

        // Random keys/frames with random ready; last key byte rides with start
        for (int r = 0; r < 3; r++) begin
            ready_mode = 2;
            for (int i = 0; i < 7; i++) write_key(8'($urandom_range(0, 255)));
            start_burst(22'($urandom), 1'b1, 8'($urandom_range(0, 255)));
            finish_burst($sformatf("random%0d", r), 2);
        end

        // Reset in the middle of MIX
        ready_mode = 0;
        start_burst(22'($urandom), 1'b0, 8'h00);
        repeat (150) tick;
        #2;
        resetn = 1'b0;
        #1;
        check("midreset_outputs",
              128'({core_clear, core_step, core_force_all, core_in_bit, ks_byte, ks_valid, busy, done}),
              128'(0));
        repeat (2) tick;
        resetn = 1'b1;
        key_model = '0;
        exp_q.delete();
        tick;
        check("midreset_idle", 128'(busy), 128'(0));
        start_burst(22'h2A5A5, 1'b0, 8'h00);
        finish_burst("zero_key", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
